// File: rtl/ap_chain_master.sv
// rtl/ap_chain_master.sv - ap_ctrl_chain initiator: issues N kernel runs, acks every done, watchdog + protocol checks
module ap_chain_master #(
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TO_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [CNT_WIDTH-1:0] cfg_num_runs,
    input  logic [TO_WIDTH-1:0]  cfg_timeout,
    input  logic                 cfg_abort,
    output logic                 k_ap_start,
    output logic                 k_ap_continue,
    input  logic                 k_ap_ready,
    input  logic                 k_ap_done,
    input  logic                 k_ap_idle,
    output logic                 busy,
    output logic                 seq_done,
    output logic [CNT_WIDTH-1:0] runs_issued,
    output logic [CNT_WIDTH-1:0] runs_completed,
    output logic                 err_timeout,
    output logic                 err_protocol
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] num_runs_q, num_runs_d;
    logic [TO_WIDTH-1:0]  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] completed_q, completed_d;
    logic [TO_WIDTH-1:0]  wdog_q, wdog_d;
    logic                 start_q, start_d;
    logic                 cont_q, cont_d;
    logic                 done_seen_q, done_seen_d;
    logic                 seq_done_q, seq_done_d;
    logic                 err_to_q, err_to_d;
    logic                 err_pr_q, err_pr_d;

    logic                 start_hs, done_hs;
    logic [CNT_WIDTH-1:0] issued_n, completed_n, outstanding_n;
    logic [TO_WIDTH-1:0]  wdog_inc;

    always_comb begin
        state_d     = state_q;
        num_runs_d  = num_runs_q;
        timeout_d   = timeout_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        wdog_d      = wdog_q;
        start_d     = start_q;
        cont_d      = cont_q;
        done_seen_d = done_seen_q;
        seq_done_d  = 1'b0;
        err_to_d    = err_to_q;
        err_pr_d    = err_pr_q;

        start_hs      = start_q && k_ap_ready;
        done_hs       = cont_q && k_ap_done;
        issued_n      = issued_q + CNT_WIDTH'(start_hs);
        completed_n   = completed_q + CNT_WIDTH'(done_hs);
        outstanding_n = issued_n - completed_n;
        wdog_inc      = wdog_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                start_d     = 1'b0;
                cont_d      = 1'b0;
                done_seen_d = 1'b0;
                if (cfg_start) begin
                    num_runs_d  = cfg_num_runs;
                    timeout_d   = cfg_timeout;
                    issued_d    = '0;
                    completed_d = '0;
                    wdog_d      = '0;
                    err_to_d    = 1'b0;
                    err_pr_d    = 1'b0;
                    if (cfg_num_runs == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        start_d = 1'b1;
                    end
                end
            end
            S_ISSUE, S_DRAIN: begin
                issued_d    = issued_n;
                completed_d = completed_n;
                // done is registered once, then continue follows; a held done re-arms only after the ack edge
                done_seen_d = k_ap_done && !done_seen_q && !cont_q;
                cont_d      = cont_q ? !done_hs : done_seen_q;
                wdog_d      = (start_hs || done_hs) ? '0 : wdog_inc;
                start_d     = (state_q == S_ISSUE) && (issued_n < num_runs_q)
                              && (outstanding_n < CNT_WIDTH'(MAX_OUTSTANDING));
                if (state_q == S_ISSUE && issued_n == num_runs_q) begin
                    state_d = S_DRAIN;
                end
                if (state_q == S_DRAIN && completed_q == num_runs_q && k_ap_idle) begin
                    state_d = S_DONE;
                end
                if (k_ap_done && issued_q == completed_q) begin
                    err_pr_d    = 1'b1;
                    state_d     = S_ERROR;
                    start_d     = 1'b0;
                    cont_d      = 1'b0;
                    done_seen_d = 1'b0;
                end else if (timeout_q != '0 && !start_hs && !done_hs && wdog_inc == timeout_q) begin
                    err_to_d    = 1'b1;
                    state_d     = S_ERROR;
                    start_d     = 1'b0;
                    cont_d      = 1'b0;
                    done_seen_d = 1'b0;
                end
            end
            S_DONE: begin
                seq_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_ERROR: begin
                start_d     = 1'b0;
                cont_d      = 1'b0;
                done_seen_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort freezes counters and flags exactly as they stood
        if (cfg_abort) begin
            state_d     = S_IDLE;
            num_runs_d  = num_runs_q;
            timeout_d   = timeout_q;
            issued_d    = issued_q;
            completed_d = completed_q;
            wdog_d      = wdog_q;
            start_d     = 1'b0;
            cont_d      = 1'b0;
            done_seen_d = 1'b0;
            seq_done_d  = 1'b0;
            err_to_d    = err_to_q;
            err_pr_d    = err_pr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_runs_q  <= '0;
            timeout_q   <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            wdog_q      <= '0;
            start_q     <= 1'b0;
            cont_q      <= 1'b0;
            done_seen_q <= 1'b0;
            seq_done_q  <= 1'b0;
            err_to_q    <= 1'b0;
            err_pr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_runs_q  <= num_runs_d;
            timeout_q   <= timeout_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            wdog_q      <= wdog_d;
            start_q     <= start_d;
            cont_q      <= cont_d;
            done_seen_q <= done_seen_d;
            seq_done_q  <= seq_done_d;
            err_to_q    <= err_to_d;
            err_pr_q    <= err_pr_d;
        end
    end

    assign k_ap_start     = start_q;
    assign k_ap_continue  = cont_q;
    assign busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign seq_done       = seq_done_q;
    assign runs_issued    = issued_q;
    assign runs_completed = completed_q;
    assign err_timeout    = err_to_q;
    assign err_protocol   = err_pr_q;

endmodule
